traffic_fsm_timer: RTL and testbench

TRAFFIC_FSM_TIMER -- requirements
Module: traffic_fsm_timer

---
 rtl/traffic_fsm_timer_if.sv | 28 ++
 rtl/traffic_fsm_timer.sv | 152 +++++++++++++++
 tb/tb_traffic_fsm_timer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_fsm_timer_if.sv
// rtl/traffic_fsm_timer_if.sv - lamp, count and night-request bundle of the two-road traffic controller
interface traffic_fsm_timer_if;
    logic       night;
    logic       X1;
    logic       V1;
    logic       D1;
    logic       X2;
    logic       V2;
    logic       D2;
    logic [7:0] cnt1_bcd;
    logic [7:0] cnt2_bcd;
    logic [2:0] phase;
    logic       sec_tick;

    // Controller side: samples night, drives lamps, counts and tick.
    modport master (
        input  night,
        output X1, V1, D1, X2, V2, D2,
        output cnt1_bcd, cnt2_bcd, phase, sec_tick
    );

    // Observer side: requests night mode, watches everything else.
    modport slave (
        output night,
        input  X1, V1, D1, X2, V2, D2,
        input  cnt1_bcd, cnt2_bcd, phase, sec_tick
    );
endinterface

// File: rtl/traffic_fsm_timer.sv
// rtl/traffic_fsm_timer.sv - two-road traffic light FSM with seconds prescaler, BCD countdowns and night mode
module traffic_fsm_timer #(
    parameter int CLK_HZ   = 50000000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 3
) (
    input  logic                 clk,
    input  logic                 rs,
    traffic_fsm_timer_if.master  bus
);
    localparam int         PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [6:0] GREEN_C  = 7'(GREEN_S);
    localparam logic [6:0] YELLOW_C = 7'(YELLOW_S);

    // Lamp vector order: {X1, V1, D1, X2, V2, D2}
    localparam logic [5:0] LAMPS_S0 = 6'b100001;
    localparam logic [5:0] LAMPS_S1 = 6'b010001;
    localparam logic [5:0] LAMPS_S2 = 6'b001100;
    localparam logic [5:0] LAMPS_S3 = 6'b001010;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        NIGHT = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [6:0]    c, c_n;
    logic          blink, blink_n;
    logic          pre_clr;
    logic [PW-1:0] pre;
    logic          tick;
    logic [5:0]    lamps, lamps_n;
    logic [7:0]    cnt1, cnt1_n, cnt2, cnt2_n;

    // Exact conversion for 0..99; larger values never reach this.
    function automatic logic [7:0] bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign tick = (pre == PRE_MAX);

    // Seconds prescaler; restarts from zero when leaving night mode.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            pre <= '0;
        end else if (pre_clr || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // State register, phase counter, blink phase and registered outputs.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state <= S0;
            c     <= GREEN_C;
            blink <= 1'b0;
            lamps <= LAMPS_S0;
            cnt1  <= bcd(GREEN_C);
            cnt2  <= bcd(GREEN_C + YELLOW_C);
        end else begin
            state <= state_n;
            c     <= c_n;
            blink <= blink_n;
            lamps <= lamps_n;
            cnt1  <= cnt1_n;
            cnt2  <= cnt2_n;
        end
    end

    // Next state: night overrides at once, otherwise phases advance on the last tick.
    always_comb begin
        state_n = state;
        c_n     = c;
        blink_n = blink;
        pre_clr = 1'b0;
        if (state == NIGHT) begin
            if (!bus.night) begin
                state_n = S0;
                c_n     = GREEN_C;
                pre_clr = 1'b1;
            end else if (tick) begin
                blink_n = ~blink;
            end
        end else if (bus.night) begin
            state_n = NIGHT;
            blink_n = 1'b1;
        end else if (tick) begin
            if (c == 7'd1) begin
                case (state)
                    S0:      begin state_n = S1; c_n = YELLOW_C; end
                    S1:      begin state_n = S2; c_n = GREEN_C;  end
                    S2:      begin state_n = S3; c_n = YELLOW_C; end
                    default: begin state_n = S0; c_n = GREEN_C;  end
                endcase
            end else begin
                c_n = c - 7'd1;
            end
        end
    end

    // Output decode from the next-state values so outputs land in the same edge as the state.
    always_comb begin
        lamps_n = 6'b001001;
        cnt1_n  = 8'h00;
        cnt2_n  = 8'h00;
        case (state_n)
            S0: begin
                lamps_n = LAMPS_S0;
                cnt1_n  = bcd(c_n);
                cnt2_n  = bcd(c_n + YELLOW_C);
            end
            S1: begin
                lamps_n = LAMPS_S1;
                cnt1_n  = bcd(c_n);
                cnt2_n  = bcd(c_n);
            end
            S2: begin
                lamps_n = LAMPS_S2;
                cnt1_n  = bcd(c_n + YELLOW_C);
                cnt2_n  = bcd(c_n);
            end
            S3: begin
                lamps_n = LAMPS_S3;
                cnt1_n  = bcd(c_n);
                cnt2_n  = bcd(c_n);
            end
            NIGHT: begin
                lamps_n = {1'b0, blink_n, 1'b0, 1'b0, blink_n, 1'b0};
            end
            default: begin
                lamps_n = 6'b001001;
            end
        endcase
    end

    assign bus.X1       = lamps[5];
    assign bus.V1       = lamps[4];
    assign bus.D1       = lamps[3];
    assign bus.X2       = lamps[2];
    assign bus.V2       = lamps[1];
    assign bus.D2       = lamps[0];
    assign bus.cnt1_bcd = cnt1;
    assign bus.cnt2_bcd = cnt2;
    assign bus.phase    = state;
    assign bus.sec_tick = tick;
endmodule

// File: tb/tb_traffic_fsm_timer.sv
// tb/tb_traffic_fsm_timer.sv - directed table and corner-sequence bench for traffic_fsm_timer
module tb_traffic_fsm_timer;
    logic clk = 1'b0;
    logic rs  = 1'b1;
    logic rs2 = 1'b1;

    always #5 clk = ~clk;

    traffic_fsm_timer_if bus1 ();
    traffic_fsm_timer_if bus2 ();

    traffic_fsm_timer #(.CLK_HZ(10), .GREEN_S(5), .YELLOW_S(2)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus1)
    );

    traffic_fsm_timer #(.CLK_HZ(2), .GREEN_S(95), .YELLOW_S(4)) dut2 (
        .clk (clk),
        .rs  (rs2),
        .bus (bus2)
    );

    logic [5:0] l1;
    assign l1 = {bus1.X1, bus1.V1, bus1.D1, bus1.X2, bus1.V2, bus1.D2};

    typedef struct {
        logic       night;
        logic [2:0] ph;
        logic [5:0] lamps;
        logic [7:0] c1;
        logic [7:0] c2;
    } vec_t;

    vec_t tbl [15];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        bit found = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            n++;
            if (bus1.sec_tick) found = 1'b1;
        end
        if (!found) chk("tick_timeout", 0, 1);
    endtask

    task automatic adv2(input int n);
        for (int i = 0; i < n; i++) begin
            bit found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (bus2.sec_tick) found = 1'b1;
            end
            if (!found) chk("tick2_timeout", 0, 1);
            @(negedge clk);
        end
    endtask

    task automatic check_out(input string tag, input int i);
        chk({tag, "_phase"}, int'(bus1.phase), int'(tbl[i].ph));
        chk({tag, "_lamps"}, int'(l1), int'(tbl[i].lamps));
        chk({tag, "_cnt1"}, int'(bus1.cnt1_bcd), int'(tbl[i].c1));
        chk({tag, "_cnt2"}, int'(bus1.cnt2_bcd), int'(tbl[i].c2));
    endtask

    task automatic run_table(input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            bus1.night = tbl[i].night;
            if (i > 0) begin
                wait_tick(gap);
                chk("tick_gap", gap, 9);
                chk("pre_edge_phase", int'(bus1.phase), int'(tbl[i-1].ph));
                @(negedge clk);
            end
            check_out("tbl", i);
        end
    endtask

    task automatic set_vec(input int i, input logic [2:0] ph, input logic [5:0] lm,
                           input logic [7:0] c1, input logic [7:0] c2);
        tbl[i].night = 1'b0;
        tbl[i].ph    = ph;
        tbl[i].lamps = lm;
        tbl[i].c1    = c1;
        tbl[i].c2    = c2;
    endtask

    function automatic bit lamp_ok();
        if (bus1.phase < 3'd4)
            return $onehot({bus1.X1, bus1.V1, bus1.D1}) && $onehot({bus1.X2, bus1.V2, bus1.D2})
                && !(bus1.X1 && bus1.X2) && (!bus1.X1 || bus1.D2) && (!bus1.X2 || bus1.D1);
        return (bus1.phase == 3'd4) && !bus1.X1 && !bus1.D1 && !bus1.X2 && !bus1.D2
            && (bus1.V1 == bus1.V2);
    endfunction

    initial begin
        int gap;
        int ticks;
        bit hit;

        set_vec(0,  3'd0, 6'b100001, 8'h05, 8'h07);
        set_vec(1,  3'd0, 6'b100001, 8'h04, 8'h06);
        set_vec(2,  3'd0, 6'b100001, 8'h03, 8'h05);
        set_vec(3,  3'd0, 6'b100001, 8'h02, 8'h04);
        set_vec(4,  3'd0, 6'b100001, 8'h01, 8'h03);
        set_vec(5,  3'd1, 6'b010001, 8'h02, 8'h02);
        set_vec(6,  3'd1, 6'b010001, 8'h01, 8'h01);
        set_vec(7,  3'd2, 6'b001100, 8'h07, 8'h05);
        set_vec(8,  3'd2, 6'b001100, 8'h06, 8'h04);
        set_vec(9,  3'd2, 6'b001100, 8'h05, 8'h03);
        set_vec(10, 3'd2, 6'b001100, 8'h04, 8'h02);
        set_vec(11, 3'd2, 6'b001100, 8'h03, 8'h01);
        set_vec(12, 3'd3, 6'b001010, 8'h02, 8'h02);
        set_vec(13, 3'd3, 6'b001010, 8'h01, 8'h01);
        set_vec(14, 3'd0, 6'b100001, 8'h05, 8'h07);

        bus1.night = 1'b0;
        bus2.night = 1'b0;

        // Wide-range instance: reset values and BCD borrow across tens.
        repeat (3) @(negedge clk);
        chk("big_rst_cnt1", int'(bus2.cnt1_bcd), 'h95);
        chk("big_rst_cnt2", int'(bus2.cnt2_bcd), 'h99);
        chk("rst_hold_tick", int'(bus1.sec_tick), 0);
        chk("rst_hold_phase", int'(bus1.phase), 0);
        rs2 = 1'b0;
        adv2(5);
        chk("big_90_cnt1", int'(bus2.cnt1_bcd), 'h90);
        chk("big_90_cnt2", int'(bus2.cnt2_bcd), 'h94);
        adv2(1);
        chk("big_89_cnt1", int'(bus2.cnt1_bcd), 'h89);
        chk("big_89_cnt2", int'(bus2.cnt2_bcd), 'h93);
        adv2(79);
        chk("big_10_cnt1", int'(bus2.cnt1_bcd), 'h10);
        adv2(1);
        chk("big_09_cnt1", int'(bus2.cnt1_bcd), 'h09);
        chk("big_09_cnt2", int'(bus2.cnt2_bcd), 'h13);
        rs2 = 1'b1;

        // Full 14-tick cycle from release.
        rs = 1'b0;
        run_table(15);

        // Into mid-S2, then night mode.
        for (int i = 0; i < 8; i++) begin
            wait_tick(gap);
            @(negedge clk);
        end
        chk("pre_night_phase", int'(bus1.phase), 2);
        chk("pre_night_cnt1", int'(bus1.cnt1_bcd), 'h06);
        repeat (3) @(negedge clk);
        bus1.night = 1'b1;
        @(negedge clk);
        chk("night_phase", int'(bus1.phase), 4);
        chk("night_lamps_on", int'(l1), 'b010010);
        chk("night_cnt1", int'(bus1.cnt1_bcd), 0);
        chk("night_cnt2", int'(bus1.cnt2_bcd), 0);
        wait_tick(gap);
        @(negedge clk);
        chk("night_lamps_off", int'(l1), 0);
        chk("night_tick_phase", int'(bus1.phase), 4);
        wait_tick(gap);
        @(negedge clk);
        chk("night_lamps_on2", int'(l1), 'b010010);
        bus1.night = 1'b0;
        @(negedge clk);
        chk("exit_phase", int'(bus1.phase), 0);
        chk("exit_lamps", int'(l1), 'b100001);
        chk("exit_cnt1", int'(bus1.cnt1_bcd), 'h05);
        chk("exit_cnt2", int'(bus1.cnt2_bcd), 'h07);
        wait_tick(gap);
        chk("exit_tick_gap", gap, 9);
        @(negedge clk);
        chk("exit_next_cnt1", int'(bus1.cnt1_bcd), 'h04);
        chk("exit_next_cnt2", int'(bus1.cnt2_bcd), 'h06);

        // Reset mid-S3 takes effect without a clock edge.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            wait_tick(gap);
            @(negedge clk);
            if (bus1.phase == 3'd3) hit = 1'b1;
        end
        chk("reach_s3", int'(hit), 1);
        repeat (3) @(negedge clk);
        rs = 1'b1;
        #1;
        chk("async_rst_phase", int'(bus1.phase), 0);
        chk("async_rst_lamps", int'(l1), 'b100001);
        chk("async_rst_cnt1", int'(bus1.cnt1_bcd), 'h05);
        chk("async_rst_cnt2", int'(bus1.cnt2_bcd), 'h07);
        chk("async_rst_tick", int'(bus1.sec_tick), 0);
        @(negedge clk);
        rs = 1'b0;
        run_table(7);

        // Night held across reset release: NIGHT one edge later.
        rs = 1'b1;
        bus1.night = 1'b1;
        @(negedge clk);
        chk("rst_night_hold_phase", int'(bus1.phase), 0);
        rs = 1'b0;
        @(negedge clk);
        chk("rst_night_phase", int'(bus1.phase), 4);
        chk("rst_night_lamps", int'(l1), 'b010010);
        bus1.night = 1'b0;
        @(negedge clk);

        // Random night pulses over 1000 ticks, lamp invariants every cycle.
        ticks = 0;
        for (int cyc = 0; cyc < 15000 && ticks < 1000; cyc++) begin
            @(negedge clk);
            if (bus1.sec_tick) ticks++;
            chk("lamp_inv", int'(lamp_ok()), 1);
            if ($urandom_range(0, 99) == 0) bus1.night = ~bus1.night;
        end
        chk("random_ticks", ticks, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
